// File: rtl/expr_eval.sv
// expr_eval: streaming evaluator for single-digit '+'/'*' ASCII expressions, '*' binding tighter.
// Ports: clk; clr (async, active-low); restart (sync clear, beats in_valid);
//        in/in_valid (ASCII character stream); result (expression value, mod 2^WIDTH);
//        ok (input ends on a digit, no error); err (sticky malformed); ovf (sticky overflow).
module expr_eval #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             restart,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             ok,
  output logic             err,
  output logic             ovf
);
  localparam int PW = WIDTH + 4;
  typedef enum logic [1:0] {IDLE, DIG, OP, ERR} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d, prod_q, prod_d, result_q, result_d;
  logic             mul_pend_q, mul_pend_d, ok_q, ok_d, err_q, err_d, ovf_q, ovf_d;
  logic             is_dig, is_mul, is_add, do_mul;
  logic [3:0]       dval;
  logic [PW-1:0]    prod_full;
  logic [WIDTH-1:0] prod_new, sum_base;
  logic [WIDTH:0]   res_full, add_full;
  // '0'..'9' are 0x30..0x39, so the low nibble is the digit value
  assign is_dig    = (in >= 8'd48) && (in <= 8'd57);
  assign is_mul    = in == 8'd42;
  assign is_add    = in == 8'd43;
  assign dval      = in[3:0];
  assign do_mul    = (state_q == OP) && mul_pend_q;
  assign prod_full = PW'(prod_q) * PW'(dval);
  assign prod_new  = do_mul ? prod_full[WIDTH-1:0] : WIDTH'(dval);
  // a fresh expression starts from an empty sum
  assign sum_base  = (state_q == IDLE) ? '0 : sum_q;
  assign res_full  = {1'b0, sum_base} + {1'b0, prod_new};
  assign add_full  = {1'b0, sum_q} + {1'b0, prod_q};
  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    prod_d     = prod_q;
    mul_pend_d = mul_pend_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    if (in_valid) begin
      case (state_q)
        IDLE, OP: begin
          if (is_dig) begin
            state_d  = DIG;
            prod_d   = prod_new;
            sum_d    = sum_base;
            result_d = res_full[WIDTH-1:0];
            ovf_d    = ovf_q | res_full[WIDTH] | (do_mul && (prod_full[PW-1:WIDTH] != '0));
          end else state_d = ERR;
        end
        DIG: begin
          if (is_add) begin
            state_d    = OP;
            sum_d      = add_full[WIDTH-1:0];
            mul_pend_d = 1'b0;
            ovf_d      = ovf_q | add_full[WIDTH];
          end else if (is_mul) begin
            state_d    = OP;
            mul_pend_d = 1'b1;
          end else state_d = ERR;
        end
        default: state_d = ERR;
      endcase
    end
    if (restart) begin
      state_d    = IDLE;
      sum_d      = '0;
      prod_d     = '0;
      mul_pend_d = 1'b0;
      result_d   = '0;
      ovf_d      = 1'b0;
    end
    ok_d  = state_d == DIG;
    err_d = state_d == ERR;
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= IDLE;
      sum_q      <= '0;
      prod_q     <= '0;
      mul_pend_q <= 1'b0;
      result_q   <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      prod_q     <= prod_d;
      mul_pend_q <= mul_pend_d;
      result_q   <= result_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end
  assign result = result_q;
  assign ok     = ok_q;
  assign err    = err_q;
  assign ovf    = ovf_q;
endmodule

// File: tb/tb_expr_eval.sv
// tb_expr_eval: directed stimulus, per-cycle check against a re-parsing expression model, plus literal expectations.
module tb_expr_eval;
  localparam int W = 16;
  localparam longint M = longint'(1) << W;
  logic         clk = 1'b0;
  logic         clr, restart, in_valid;
  logic [7:0]   in_c;
  logic [W-1:0] result;
  logic         ok, err, ovf;
  int           tests = 0;
  int           fails = 0;
  logic [7:0]   hist[$];
  longint       m_res;
  bit           m_ok, m_err, m_ovf;
  expr_eval #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .restart(restart), .in(in_c), .in_valid(in_valid),
    .result(result), .ok(ok), .err(err), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Re-evaluates the whole character history since the last clear from scratch.
  function automatic void model();
    longint sum = 0, term = 0;
    bit want_digit = 1, mul = 0;
    m_res = 0; m_ok = 0; m_err = 0; m_ovf = 0;
    foreach (hist[i]) begin
      logic [7:0] c = hist[i];
      if (m_err) continue;
      if (want_digit) begin
        if (c >= "0" && c <= "9") begin
          term = mul ? term * longint'(c - "0") : longint'(c - "0");
          if (term >= M) m_ovf = 1;
          term = term % M;
          if (sum + term >= M) m_ovf = 1;
          m_res = (sum + term) % M;
          want_digit = 0;
          m_ok = 1;
        end else m_err = 1;
      end else if (c == "+") begin
        sum = sum + term;
        if (sum >= M) m_ovf = 1;
        sum = sum % M;
        mul = 0; want_digit = 1; m_ok = 0;
      end else if (c == "*") begin
        mul = 1; want_digit = 1; m_ok = 0;
      end else m_err = 1;
    end
    if (m_err) m_ok = 0;
  endfunction
  always @(negedge clr) hist.delete();
  always @(posedge clk) begin
    if (!clr || restart) hist.delete();
    else if (in_valid) hist.push_back(in_c);
    #1;
    model();
    check("mdl_result", longint'(result), m_res);
    check("mdl_ok", longint'(ok), longint'(m_ok));
    check("mdl_err", longint'(err), longint'(m_err));
    check("mdl_ovf", longint'(ovf), longint'(m_ovf));
  end
  task automatic send(input logic [7:0] c);
    @(negedge clk);
    in_c = c; in_valid = 1'b1; restart = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #1;
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask
  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1; in_valid = 1'b1; in_c = "9";
    @(posedge clk);
    #1 restart = 1'b0; in_valid = 1'b0;
    #1;
  endtask
  task automatic expect4(input string tag, input longint r, input bit o, input bit e, input bit v);
    check({tag, "_result"}, longint'(result), r);
    check({tag, "_ok"}, longint'(ok), longint'(o));
    check({tag, "_err"}, longint'(err), longint'(e));
    check({tag, "_ovf"}, longint'(ovf), longint'(v));
  endtask
  initial begin
    clr = 1'b0; restart = 1'b0; in_valid = 1'b0; in_c = 8'd0;
    #12;
    expect4("reset", 0, 0, 0, 0);
    @(negedge clk) clr = 1'b1;
    send("2"); expect4("t1_d2", 2, 1, 0, 0);
    send("+"); expect4("t1_add", 2, 0, 0, 0);
    send("3"); expect4("t1_d3", 5, 1, 0, 0);
    send("*"); expect4("t1_mul", 5, 0, 0, 0);
    send("4"); expect4("t1_d4", 14, 1, 0, 0);
    do_restart(); expect4("restart_drop", 0, 0, 0, 0);
    send_str("0*1+"); expect4("t2_add", 0, 0, 0, 0);
    send("7"); expect4("t2_d7", 7, 1, 0, 0);
    do_restart();
    send_str("1++"); expect4("t3_err", 1, 0, 1, 0);
    send("5"); expect4("t3_sticky", 1, 0, 1, 0);
    do_restart(); expect4("t3_restart", 0, 0, 0, 0);
    send("8"); expect4("t3_d8", 8, 1, 0, 0);
    do_restart();
    send_str("9*9*9*9*9"); expect4("t4_pow5", 59049, 1, 0, 0);
    send_str("*9"); expect4("t4_pow6", 7153, 1, 0, 1);
    send("a"); expect4("t4_err_keeps_ovf", 7153, 0, 1, 1);
    do_restart(); expect4("t4_restart", 0, 0, 0, 0);
    send_str("9*9*9*9*9+9*9*9*9*9"); expect4("sum_ovf", 52562, 1, 0, 1);
    do_restart();
    send_str("34"); expect4("t5_dd", 3, 0, 1, 0);
    do_restart();
    send_str("5a"); expect4("t5_other", 5, 0, 1, 0);
    do_restart();
    send_str("4*");
    repeat (3) @(posedge clk);
    #2 expect4("t6_gap", 4, 0, 0, 0);
    send("3"); expect4("t6_d3", 12, 1, 0, 0);
    #1 clr = 1'b0;
    #1 expect4("t6_async_clr", 0, 0, 0, 0);
    @(negedge clk);
    clr = 1'b1; in_c = "6"; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #1 expect4("t6_after_clr", 6, 1, 0, 0);
    repeat (2) @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/expr_eval.md
# expr_eval

Streaming arithmetic evaluator that sits directly downstream of the ASCII expression recognizer and consumes the same 8-bit character stream. It accepts single-digit operands joined by `+` and `*`, applying `*` before `+`, and keeps a running value of the expression received so far. It also flags malformed input and arithmetic overflow. The result is held stable so a later stage can sample it whenever `ok` is high.

## Interface
- `WIDTH`, default 16: width of the result and internal accumulators. Must be ≥ 4.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `clr`, input, 1: reset, asynchronous, active-low. Clears all state and outputs.
- `restart`, input, 1: synchronous restart. Same effect as reset, applied on the next edge. Priority over `in_valid`.
- `in`, input, 8: ASCII character.
- `in_valid`, input, 1: `in` is consumed on an edge where this is high. When low, all state holds.
- `result`, output, WIDTH: value of the expression up to the last accepted digit, modulo 2^WIDTH.
- `ok`, output, 1: the characters consumed so far form a complete expression, i.e. they end on a digit with no error.
- `err`, output, 1: sticky. Set by a malformed sequence.
- `ovf`, output, 1: sticky. Set when any product or sum exceeds 2^WIDTH−1.

## Operation

**Character classes**
- digit: 48–57 (value = `in` − 48)
- MUL: 42 (`*`)
- ADD: 43 (`+`)
- OTHER: anything else

**Registers**
- `sum`: committed terms
- `prod`: current product term
- `mul_pend`: last operator was `*`
- `state`

**States**
- IDLE: start; a digit is expected.
  - digit d → DIG; `sum`=0, `prod`=d.
  - MUL, ADD or OTHER → ERR.
- DIG: last character was a digit.
  - ADD → OP; `sum`=`sum`+`prod`; `mul_pend`=0.
  - MUL → OP; `mul_pend`=1.
  - digit or OTHER → ERR. Operands are single-digit, so two digits in a row is an error.
- OP: last character was an operator.
  - digit d → DIG; `prod` = `mul_pend` ? `prod`·d : d.
  - MUL, ADD or OTHER → ERR.
- ERR: absorbing. Leaves only on `clr` or `restart`.

**Outputs**
- `result` is registered and loads `sum_next`+`prod_next` only on transitions into DIG. It holds in all other cases, including entry to OP and ERR.
- `ok` = (`state`==DIG), registered.
- `err` = (`state`==ERR).
- `ovf` is set on the edge where a true (unbounded) product or sum for `prod`, `sum`, or `result` ≥ 2^WIDTH. All stored values wrap modulo 2^WIDTH.
- `ovf` is cleared only by `clr`/`restart`. It is unaffected by ERR.

**Reset and restart**
- Reset values: `result`=0, `ok`=0, `err`=0, `ovf`=0, `state`=IDLE, `sum`=`prod`=`mul_pend`=0.
- `clr` low mid-expression forces these values immediately, without waiting for a clock edge.
- `restart` together with `in_valid`: the restart wins and the character is dropped.

## Timing
- Latency 1: a character sampled at edge k is reflected in `result`/`ok`/`err`/`ovf` after edge k.
- Throughput: one character per cycle. `in_valid` may be held high continuously.
- No backpressure; the block is always ready.
- Gaps with `in_valid` low insert no state change.
- `clr` deassertion is synchronized by the user. The first edge after release can consume a character.

## Test plan
1. Reset, then `in`="2","+","3","*","4" on consecutive cycles with `in_valid`=1 → after each edge:
   - `result`=2,2,5,5,14
   - `ok`=1,0,1,0,1
   - `err`=0 throughout
2. "0","*","1","+" → `result`=0, `ok`=0 after the final `+`. Then "7" → `result`=7, `ok`=1.
3. "1","+","+" → `err`=1 after the third edge, `ok`=0, `result` holds 1. A following "5" leaves `err`=1. `restart` pulse → `err`=0, `result`=0. Then "8" → `result`=8, `ok`=1.
4. WIDTH=16: "9" followed by "*9" ×5 →
   - after the fifth digit: `result`=59049, `ovf`=0
   - after the sixth digit: `result`=7153 (531441 mod 65536), `ovf`=1, `ok`=1
5. "3","4" (digit after digit) → `err`=1. Separately, "5","a" (OTHER) → `err`=1.
6. "4","*", then `in_valid` low for 3 cycles → state held: `ok`=0, `result`=4. Then "3" → `result`=12. Assert `clr` low between edges → outputs 0 immediately.
